// File: rtl/fir_decimator.sv
// Block-averaging decimator behind the PIG FIR low-pass filter.
// Averages 2^k valid samples per frame with round-half-up; error-hit frames are dropped and counted.
module fir_decimator #(
    parameter int IN_W     = 18,
    parameter int MAX_LOG2 = 8,
    parameter int CNT_W    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic signed [IN_W-1:0] i_data,
    input  logic                   i_valid,
    input  logic [1:0]             i_err,
    input  logic [3:0]             i_dec_log2,
    input  logic                   i_clear,
    output logic signed [IN_W-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_drop,
    output logic [CNT_W-1:0]       o_drop_cnt
);

    localparam int         ACC_W  = IN_W + MAX_LOG2;
    localparam int         SCNT_W = MAX_LOG2 + 1;
    localparam logic [3:0] MAX_K  = 4'(MAX_LOG2);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DISCARD} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [SCNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]               k_q, k_d;
    logic signed [IN_W-1:0]   o_data_q, o_data_d;
    logic                     o_valid_q, o_valid_d;
    logic                     o_drop_q, o_drop_d;
    logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;

    logic                     frame_open;
    logic [3:0]               k_eff;
    logic signed [ACC_W-1:0]  data_ext, acc_base, sum, round_add, rounded;
    logic [SCNT_W-1:0]        cnt_base, cnt_inc;
    logic                     frame_done;

    // A sample outside an open frame (idle or discard cycle) starts a new frame from zero.
    always_comb begin
        frame_open = (state_q == S_ACC);
        k_eff      = frame_open ? k_q : ((i_dec_log2 > MAX_K) ? MAX_K : i_dec_log2);
        acc_base   = frame_open ? acc_q : '0;
        cnt_base   = frame_open ? cnt_q : '0;
        data_ext   = {{MAX_LOG2{i_data[IN_W-1]}}, i_data};
        sum        = acc_base + data_ext;
        cnt_inc    = cnt_base + SCNT_W'(1);
        round_add  = (k_eff == 4'd0) ? '0 : (ACC_W'(1) << (k_eff - 4'd1));
        rounded    = (sum + round_add) >>> k_eff;
        frame_done = (cnt_inc == (SCNT_W'(1) << k_eff));
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        o_data_d   = o_data_q;
        o_valid_d  = 1'b0;
        o_drop_d   = 1'b0;
        drop_cnt_d = drop_cnt_q;

        if (i_clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            if (state_q == S_DISCARD) begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
            if (i_valid) begin
                if (i_err == 2'b00) begin
                    k_d = k_eff;
                    if (frame_done) begin
                        o_data_d  = IN_W'(rounded);
                        o_valid_d = 1'b1;
                        state_d   = S_IDLE;
                        acc_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        acc_d   = sum;
                        cnt_d   = cnt_inc;
                        state_d = S_ACC;
                    end
                end else begin
                    o_drop_d = 1'b1;
                    if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = frame_open ? S_DISCARD : S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            o_data_q   <= '0;
            o_valid_q  <= 1'b0;
            o_drop_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            o_data_q   <= o_data_d;
            o_valid_q  <= o_valid_d;
            o_drop_q   <= o_drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_data     = o_data_q;
    assign o_valid    = o_valid_q;
    assign o_drop     = o_drop_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Table-driven bench for fir_decimator: each row gives one cycle of inputs and
// the registered outputs expected right after that clock edge.
module tb_fir_decimator;

    logic               clk;
    logic               rst;
    logic signed [17:0] data;
    logic               valid;
    logic [1:0]         err;
    logic [3:0]         dec_log2;
    logic               clear;
    logic signed [17:0] o_data;
    logic               o_valid;
    logic               o_drop;
    logic [15:0]        o_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         rst;
        bit         clr;
        bit         vld;
        logic [1:0] err;
        logic [3:0] k;
        int         din;
        bit         e_vld;
        bit         e_drop;
        int         e_dat;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    fir_decimator #(.IN_W(18), .MAX_LOG2(8), .CNT_W(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data     (data),
        .i_valid    (valid),
        .i_err      (err),
        .i_dec_log2 (dec_log2),
        .i_clear    (clear),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input bit r, input bit c, input bit v, input logic [1:0] e,
                                input logic [3:0] k, input int din, input bit ev,
                                input bit ed, input int edat, input int ecnt);
        vec_t x;
        x.rst = r;  x.clr = c;  x.vld = v;  x.err = e;  x.k = k;  x.din = din;
        x.e_vld = ev;  x.e_drop = ed;  x.e_dat = edat;  x.e_cnt = ecnt;
        vecs.push_back(x);
    endfunction

    initial begin
        int last;
        int s;

        // Constant 1000, k=2: an output after every 4th sample.
        for (int i = 1; i <= 16; i++)
            add(0, 0, 1, 2'b00, 4'd2, 1000, (i % 4) == 0, 0, (i >= 4) ? 1000 : 0, 0);

        // Round half up, positive and negative.
        add(0, 0, 1, 2'b00, 4'd1,  1, 0, 0, 1000, 0);
        add(0, 0, 1, 2'b00, 4'd1,  2, 1, 0,    2, 0);
        add(0, 0, 1, 2'b00, 4'd1, -1, 0, 0,    2, 0);
        add(0, 0, 1, 2'b00, 4'd1, -2, 1, 0,   -1, 0);
        add(0, 0, 1, 2'b00, 4'd2,  1, 0, 0,   -1, 0);
        add(0, 0, 1, 2'b00, 4'd2,  1, 0, 0,   -1, 0);
        add(0, 0, 1, 2'b00, 4'd2,  1, 0, 0,   -1, 0);
        add(0, 0, 1, 2'b00, 4'd2,  0, 1, 0,    1, 0);   // (3+2)>>>2 = 1
        add(0, 0, 1, 2'b00, 4'd2, -2, 0, 0,    1, 0);
        add(0, 0, 1, 2'b00, 4'd2, -2, 0, 0,    1, 0);
        add(0, 0, 1, 2'b00, 4'd2, -2, 0, 0,    1, 0);
        add(0, 0, 1, 2'b00, 4'd2, -1, 1, 0,   -2, 0);   // (-7+2)>>>2 = -2

        // k=0: a 14-bit sine passes straight through, with idle gaps holding o_data.
        last = -2;
        for (int i = 0; i < 500; i += 7) begin
            s = $rtoi(8191.0 * $sin(2.0 * 3.14159265358979 * i / 500.0));
            add(0, 0, 1, 2'b00, 4'd0, s, 1, 0, s, 0);
            last = s;
            if (i % 2 == 1) add(0, 0, 0, 2'b00, 4'd0, 12345, 0, 0, last, 0);
        end

        // Full-scale frames at k=8; the second requests k=15, clamped to 8.
        for (int i = 0; i < 256; i++)
            add(0, 0, 1, 2'b00, 4'd8, 131071, i == 255, 0, (i == 255) ? 131071 : last, 0);
        for (int i = 0; i < 256; i++)
            add(0, 0, 1, 2'b00, 4'd15, -131072, i == 255, 0, (i == 255) ? -131072 : 131071, 0);

        // Error mid-frame: drop, then a fresh frame starting in the discard cycle.
        for (int i = 0; i < 5; i++) add(0, 0, 1, 2'b00, 4'd3, 10, 0, 0, -131072, 0);
        add(0, 0, 1, 2'b01, 4'd3, 10, 0, 1, -131072, 1);
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, 2'b00, 4'd3, 100, i == 7, 0, (i == 7) ? 100 : -131072, 1);
        add(0, 0, 1, 2'b10, 4'd3, 100, 0, 1, 100, 2);   // error while idle
        add(0, 0, 0, 2'b11, 4'd3, 100, 0, 0, 100, 2);   // error ignored without valid
        add(0, 0, 1, 2'b00, 4'd3, 100, 0, 0, 100, 2);
        add(0, 0, 1, 2'b00, 4'd3, 100, 0, 0, 100, 2);
        add(0, 0, 1, 2'b11, 4'd3, 100, 0, 1, 100, 3);
        add(0, 0, 1, 2'b01, 4'd3, 100, 0, 1, 100, 4);   // error during the discard cycle

        // k latched at frame start: 2 for the first frame, then 1.
        for (int i = 1; i <= 8; i++)
            add(0, 0, 1, 2'b00, (i <= 2) ? 4'd2 : 4'd1, 50,
                (i == 4) || (i == 6) || (i == 8), 0, (i >= 4) ? 50 : 100, 4);

        // Reset mid-frame (reset wins over a coincident sample), then gapped samples of 7.
        for (int i = 0; i < 3; i++) add(0, 0, 1, 2'b00, 4'd2, 1000, 0, 0, 50, 4);
        add(1, 0, 1, 2'b00, 4'd2, 1000, 0, 0, 0, 0);
        add(0, 0, 1, 2'b00, 4'd2, 7, 0, 0, 0, 0);
        add(0, 0, 0, 2'b00, 4'd2, 7, 0, 0, 0, 0);
        add(0, 0, 1, 2'b00, 4'd2, 7, 0, 0, 0, 0);
        add(0, 0, 1, 2'b00, 4'd2, 7, 0, 0, 0, 0);
        add(0, 0, 0, 2'b00, 4'd2, 7, 0, 0, 0, 0);
        add(0, 0, 1, 2'b00, 4'd2, 7, 1, 0, 7, 0);

        // Clear mid-frame: coincident sample ignored, no drop, counter kept.
        add(0, 0, 1, 2'b01, 4'd2, 7, 0, 1, 7, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 2'b00, 4'd2, 1000, 0, 0, 7, 1);
        add(0, 1, 1, 2'b00, 4'd2, 1000, 0, 0, 7, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 2'b00, 4'd2, 9, i == 3, 0, (i == 3) ? 9 : 7, 1);

        // Reset state.
        rst = 1'b1;  data = '0;  valid = 1'b0;  err = 2'b00;  dec_log2 = 4'd0;  clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset o_data", int'(o_data), 0);
        check("reset o_valid", int'(o_valid), 0);
        check("reset o_drop", int'(o_drop), 0);
        check("reset o_drop_cnt", int'(o_drop_cnt), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            clear    = vecs[i].clr;
            valid    = vecs[i].vld;
            err      = vecs[i].err;
            dec_log2 = vecs[i].k;
            data     = 18'(vecs[i].din);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d o_valid", i), int'(o_valid), int'(vecs[i].e_vld));
            check($sformatf("vec%0d o_drop", i), int'(o_drop), int'(vecs[i].e_drop));
            check($sformatf("vec%0d o_data", i), int'(o_data), vecs[i].e_dat);
            check($sformatf("vec%0d o_drop_cnt", i), int'(o_drop_cnt), vecs[i].e_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the PIG FIR low-pass filter. Consumes the filter's 18-bit signed output stream, its valid strobe and its 2-bit error code.
- Block-averages 2^k consecutive valid samples and emits one rounded average per frame. This decimates the gyro signal to the loop/output rate.
- Frames hit by a filter error are discarded and counted.

Parameters:
- IN_W, 18, sample width (signed, two's complement); output width equals IN_W.
- MAX_LOG2, 8, maximum decimation exponent; accumulator width = IN_W + MAX_LOG2.
- CNT_W, 16, width of the dropped-frame counter.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  IN_W  signed filter output sample.
- i_valid  in  1  qualifies i_data and i_err; one sample per high cycle.
- i_err  in  2  filter source error code; nonzero means error (only sampled when i_valid=1).
- i_dec_log2  in  4  decimation exponent k; values above MAX_LOG2 are clamped to MAX_LOG2.
- i_clear  in  1  synchronous flush of the current frame; counter is kept.
- o_data  out  IN_W  signed decimated average.
- o_valid  out  1  one-cycle pulse; o_data is valid.
- o_drop  out  1  one-cycle pulse; a frame was discarded because of an error.
- o_drop_cnt  out  CNT_W  saturating count of discarded frames.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values: o_data=0, o_valid=0, o_drop=0, o_drop_cnt=0. Accumulator and sample counter are 0; state is S_IDLE.
- States:
  - S_IDLE: no frame open.
  - S_ACC: frame open.
  - S_DISCARD: error seen, frame aborted.
- S_IDLE:
  - On i_valid with i_err==0: latch k_lat=clamp(i_dec_log2), acc=sign-extended i_data, cnt=1.
  - If k_lat==0, the frame completes immediately (see completion); otherwise go to S_ACC.
  - On i_valid with i_err!=0: pulse o_drop, increment the counter, stay in S_IDLE.
- S_ACC:
  - On i_valid with i_err==0: acc+=i_data, cnt+=1.
  - When cnt reaches 2^k_lat, the frame completes and the state returns to S_IDLE.
  - On i_valid with i_err!=0: go to S_DISCARD.
- Completion: o_data = (final_sum + 2^(k_lat-1)) >>> k_lat (arithmetic shift, round half up). For k_lat=0, o_data = final_sum. o_valid pulses for one cycle.
- Latency: o_valid is high in the cycle after the i_valid that carries the frame's last sample. o_data holds its value until the next completion.
- Width: the accumulator is IN_W+MAX_LOG2 bits and never overflows. The rounded average always fits in IN_W bits; no saturation is needed.
- S_DISCARD:
  - Entered with o_drop=1 and o_drop_cnt+1 (the counter saturates at all-ones), registered one cycle after the erroring sample.
  - Clears acc/cnt and returns to S_IDLE on the next cycle.
  - The next valid sample starts a fresh frame. A valid sample arriving during the S_DISCARD cycle is treated as in S_IDLE (starts a new frame).
- i_dec_log2 is latched only at frame start; changes mid-frame take effect at the next frame.
- i_clear: abandons the current frame (acc/cnt=0, state S_IDLE), with no o_drop pulse and no counter increment. i_clear has priority over a coincident i_valid, and that sample is ignored.
- i_rst has priority over everything. Reset mid-frame discards the partial sum silently.
- Gaps in i_valid (any length) are allowed; only valid cycles count toward the frame.
- o_valid and o_drop never assert in the same cycle.

Test Plan:
- k=2, constant i_data=1000 on every cycle for 16 samples -> 4 o_valid pulses, each o_data=1000, each one cycle after samples 4, 8, 12 and 16.
- k=1, samples (1, 2) then (-1, -2) -> o_data=2, then o_data=-1 (round half up: 3+1>>>1=2, -3+1>>>1=-1).
- k=0, 14-bit sine (amplitude 8191, 500 pts/period) sign-extended -> o_data equals i_data delayed by one cycle on every valid; no o_drop.
- k=3, 5 good samples, then one sample with i_err=2'b01, then 8 samples of 100 -> o_drop pulse, o_drop_cnt=1, then a single o_valid with o_data=100.
- k=2 latched, i_dec_log2 changed to 1 after sample 2, constant 50 -> first output after sample 4, subsequent outputs every 2 samples, all 50.
- i_rst or i_clear asserted after 3 of 4 samples (k=2) -> no o_valid. The next 4 samples of 7 give o_data=7. o_drop_cnt is 0 after i_rst and unchanged after i_clear.
